// File: rtl/sub_bytes_serial.sv
// rtl/sub_bytes_serial.sv - Serial SubBytes/SubWord sequencer around one shared external S-box
//
// Takes a whole AES state (or a key-schedule word) per handshake and feeds it
// one byte per cycle, LSB byte first, through an external combinational S-box.
// The substituted bytes are reassembled in their original positions.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_data             state to substitute, byte i = in_data[8i+7:8i]
//   in_encrypt          1 = forward S-box, 0 = inverse, sampled with in_data
//   sbox_byte_in        byte presented to the external S-box
//   sbox_encrypt        direction select to the external S-box
//   sbox_byte_out       S-box result, combinational from the two above
//   out_valid/out_ready output handshake
//   out_data            substituted state, same byte order as in_data
module sub_bytes_serial #(
  parameter int STATE_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*STATE_BYTES-1:0] in_data,
  input  logic                     in_encrypt,
  output logic [7:0]               sbox_byte_in,
  output logic                     sbox_encrypt,
  input  logic [7:0]               sbox_byte_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*STATE_BYTES-1:0] out_data
);

  localparam int CW = $clog2(STATE_BYTES);
  localparam logic [CW-1:0] LAST = CW'(STATE_BYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [8*STATE_BYTES-1:0] in_buf_q, in_buf_d;
  logic [8*STATE_BYTES-1:0] res_q, res_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     enc_q, enc_d;
  logic                     accept;

  // A finished result may hand off and a new state may load on the same edge,
  // so DONE can accept directly when the downstream side is taking the output.
  assign in_ready     = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept       = in_valid & in_ready;
  assign out_valid    = (state_q == DONE);
  assign out_data     = res_q;
  assign sbox_encrypt = enc_q;
  // Only the RUN state exposes real data to the S-box; otherwise park at zero.
  assign sbox_byte_in = (state_q == RUN) ? in_buf_q[7:0] : 8'h00;

  always_comb begin
    state_d  = state_q;
    in_buf_d = in_buf_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    enc_d    = enc_q;

    case (state_q)
      IDLE: begin
      end
      RUN: begin
        res_d[8*cnt_q +: 8] = sbox_byte_out;
        in_buf_d            = in_buf_q >> 8;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance only happens in IDLE or DONE, so it never collides with RUN.
    if (accept) begin
      in_buf_d = in_data;
      enc_d    = in_encrypt;
      cnt_d    = '0;
      state_d  = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      in_buf_q <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      enc_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_buf_q <= in_buf_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      enc_q    <= enc_d;
    end
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// tb/tb_sub_bytes_serial.sv - Self-checking bench for sub_bytes_serial (16-byte and 4-byte instances)
module tb_sub_bytes_serial;

  logic clk;
  logic rst_n;

  logic         iv[2];
  logic         ienc[2];
  logic         ordy[2];
  logic [127:0] idata[2];

  logic         ir16, ov16, sbe16;
  logic [7:0]   sbi16, sbo16;
  logic [127:0] od16;
  logic         ir4, ov4, sbe4;
  logic [7:0]   sbi4, sbo4;
  logic [31:0]  od4;

  logic         ir[2], ov[2], sbe[2];
  logic [7:0]   sbi[2];
  logic [127:0] od[2];

  logic [7:0] fwd[256];
  logic [7:0] inv_t[256];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } out_t;
  out_t got[$];

  sub_bytes_serial #(.STATE_BYTES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir16), .in_data(idata[0]), .in_encrypt(ienc[0]),
    .sbox_byte_in(sbi16), .sbox_encrypt(sbe16), .sbox_byte_out(sbo16),
    .out_valid(ov16), .out_ready(ordy[0]), .out_data(od16)
  );

  sub_bytes_serial #(.STATE_BYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir4), .in_data(idata[1][31:0]), .in_encrypt(ienc[1]),
    .sbox_byte_in(sbi4), .sbox_encrypt(sbe4), .sbox_byte_out(sbo4),
    .out_valid(ov4), .out_ready(ordy[1]), .out_data(od4)
  );

  // Bench-side S-boxes built from the GF(2^8) definition.
  assign sbo16 = sbe16 ? fwd[sbi16] : inv_t[sbi16];
  assign sbo4  = sbe4  ? fwd[sbi4]  : inv_t[sbi4];

  assign ir[0] = ir16;  assign ir[1] = ir4;
  assign ov[0] = ov16;  assign ov[1] = ov4;
  assign sbe[0] = sbe16; assign sbe[1] = sbe4;
  assign sbi[0] = sbi16; assign sbi[1] = sbi4;
  assign od[0] = od16;  assign od[1] = {96'd0, od4};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] x, s;
    for (int a = 0; a < 256; a++) begin
      x = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) x = 8'(b);
      end
      s = x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
      fwd[a]  = s;
      inv_t[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] din, input logic enc, input int n);
    logic [127:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r[8*i +: 8] = enc ? fwd[din[8*i +: 8]] : inv_t[din[8*i +: 8]];
    end
    return r;
  endfunction

  // Reference behaviour: phase 0 = waiting, 1 = streaming byte pos, 2 = holding result.
  int           ph[2];
  int           pos[2];
  logic         cenc[2];
  logic [127:0] cdata[2];
  logic [127:0] expv[2];
  int           p0;
  int           nb;

  initial begin
    ph[0] = 0; ph[1] = 0; cenc[0] = 1'b1; cenc[1] = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        nb = (d == 0) ? 16 : 4;
        if (!rst_n) begin
          ph[d]   = 0;
          cenc[d] = 1'b1;
          chk("rst_ov", 128'(ov[d]), 128'd0);
          chk("rst_ir", 128'(ir[d]), 128'd1);
          chk("rst_od", od[d], 128'd0);
          chk("rst_sbi", 128'(sbi[d]), 128'd0);
        end else begin
          p0 = ph[d];
          chk("sbe", 128'(sbe[d]), 128'(cenc[d]));
          case (p0)
            0: begin
              chk("idle_ov", 128'(ov[d]), 128'd0);
              chk("idle_ir", 128'(ir[d]), 128'd1);
              chk("idle_sbi", 128'(sbi[d]), 128'd0);
            end
            1: begin
              chk("run_ov", 128'(ov[d]), 128'd0);
              chk("run_ir", 128'(ir[d]), 128'd0);
              chk("run_sbi", 128'(sbi[d]), 128'(cdata[d][8*pos[d] +: 8]));
              pos[d]++;
              if (pos[d] == nb) ph[d] = 2;
            end
            default: begin
              chk("done_ov", 128'(ov[d]), 128'd1);
              chk("done_ir", 128'(ir[d]), 128'(ordy[d]));
              chk("done_sbi", 128'(sbi[d]), 128'd0);
              chk("done_od", od[d], expv[d]);
            end
          endcase
          if (p0 == 2 && ordy[d]) begin
            got.push_back('{od[d], cyc});
            ph[d] = 0;
          end
          if ((p0 == 0 || (p0 == 2 && ordy[d])) && iv[d]) begin
            cdata[d] = idata[d];
            cenc[d]  = ienc[d];
            expv[d]  = model(idata[d], ienc[d], nb);
            pos[d]   = 0;
            ph[d]    = 1;
          end
        end
      end
    end
  end

  // All drivers run at posedge+1 so the negedge monitor sees settled inputs.
  task automatic send(input int d, input logic [127:0] data, input logic enc, input logic keep);
    bit ok = 0;
    idata[d] = data;
    ienc[d]  = enc;
    iv[d]    = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (ir[d]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready=0, want 1 within 300 cycles");
    end
    @(posedge clk); #1;
    if (!keep) iv[d] = 1'b0;
  endtask

  task automatic wait_out(output logic [127:0] data, output int c);
    bit ok = 0;
    data = 'x;
    c    = 0;
    for (int t = 0; t < 300; t++) begin
      if (got.size() > 0) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      data = got[0].data;
      c    = got[0].cyc;
      void'(got.pop_front());
    end else begin
      n_cmp++; n_bad++;
      $display("FAIL out_timeout: got no output, want one within 300 cycles");
    end
  endtask

  logic [127:0] r0, r1, r2;
  int           c0, c1, c2;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ienc[d] = 1'b1; ordy[d] = 1'b1; idata[d] = '0;
    end
    build_tables();

    chk("pin_fwd00", 128'(fwd[8'h00]), 128'h63);
    chk("pin_fwd01", 128'(fwd[8'h01]), 128'h7c);
    chk("pin_fwd53", 128'(fwd[8'h53]), 128'hed);
    chk("pin_inv63", 128'(inv_t[8'h63]), 128'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_od16", od16, 128'd0);
    chk("reset_ir16", 128'(ir16), 128'd1);
    chk("reset_ov16", 128'(ov16), 128'd0);
    chk("reset_sbe16", 128'(sbe16), 128'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Forward on the ascending state.
    send(0, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1, 1'b0);
    wait_out(r0, c0);
    chk("fwd16_data", r0, 128'h76abd7fe2b670130c56f6bf27b777c63);

    // Inverse of all-0x63.
    send(0, {16{8'h63}}, 1'b0, 1'b0);
    wait_out(r0, c0);
    chk("inv16_data", r0, 128'd0);

    // Backpressure with a second state waiting.
    ordy[0] = 1'b0;
    send(0, {16{8'h10}}, 1'b1, 1'b0);
    idata[0] = {16{8'h20}};
    iv[0]    = 1'b1;
    for (int t = 0; t < 40 && !ov16; t++) begin
      @(posedge clk); #1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("bp_ir", 128'(ir16), 128'd0);
    chk("bp_od", od16, {16{8'hca}});
    ordy[0] = 1'b1;
    send(0, {16{8'h20}}, 1'b1, 1'b0);
    wait_out(r0, c0);
    wait_out(r1, c1);
    chk("bp_first", r0, {16{8'hca}});
    chk("bp_second", r1, {16{8'hb7}});
    chk("bp_spacing", 128'(c1 - c0), 128'd17);

    // Back-to-back with in_valid held high.
    send(0, {16{8'h00}}, 1'b1, 1'b1);
    send(0, {16{8'h01}}, 1'b1, 1'b1);
    send(0, {16{8'h53}}, 1'b1, 1'b0);
    wait_out(r0, c0);
    wait_out(r1, c1);
    wait_out(r2, c2);
    chk("b2b_0", r0, {16{8'h63}});
    chk("b2b_1", r1, {16{8'h7c}});
    chk("b2b_2", r2, {16{8'hed}});
    chk("b2b_gap01", 128'(c1 - c0), 128'd17);
    chk("b2b_gap12", 128'(c2 - c1), 128'd17);

    // Reset during the fifth streaming cycle.
    send(0, {16{8'h53}}, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", 128'(ov16), 128'd0);
    chk("midrst_ir", 128'(ir16), 128'd1);
    chk("midrst_sbi", 128'(sbi16), 128'd0);
    chk("midrst_sbe", 128'(sbe16), 128'd1);
    chk("midrst_od", od16, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_pulse", 128'(got.size()), 128'd0);
    send(0, {16{8'h01}}, 1'b1, 1'b0);
    wait_out(r0, c0);
    chk("midrst_fresh", r0, {16{8'h7c}});

    // Four-byte SubWord instance.
    send(1, 128'h0f0e0d0c, 1'b1, 1'b0);
    wait_out(r0, c0);
    chk("word_fwd", r0, 128'h76abd7fe);
    send(1, 128'h76abd7fe, 1'b0, 1'b0);
    wait_out(r0, c0);
    chk("word_inv", r0, 128'h0f0e0d0c);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_serial.md
# sub_bytes_serial

Serial SubBytes sequencer. It accepts a full AES state (or a 4-byte key-schedule word) over a valid/ready handshake and streams it one byte per cycle through a single shared combinational S-box, connected through dedicated ports. It reassembles the results and presents them on a valid/ready output. It sits directly upstream and downstream of the S-box: it drives the S-box input and encrypt select, and consumes the S-box output byte.

## Interface
- STATE_BYTES, 16, bytes per transaction; legal values 4 (SubWord) or 16 (SubBytes).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream has a transaction.
- in_ready  output  1  block can accept a transaction this cycle.
- in_data  input  8*STATE_BYTES  state; byte i = in_data[8i+7:8i].
- in_encrypt  input  1  1 = forward S-box, 0 = inverse; sampled with in_data.
- sbox_byte_in  output  8  byte presented to the S-box.
- sbox_encrypt  output  1  encrypt select to the S-box.
- sbox_byte_out  input  8  S-box result, combinational from sbox_byte_in/sbox_encrypt.
- out_valid  output  1  out_data holds a completed transaction.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  8*STATE_BYTES  substituted state, same byte order as in_data.

One clock; reset is asynchronous and active-low.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- Registers:
  - in_buf: STATE_BYTES bytes, shifted right by one byte per RUN cycle.
  - res: STATE_BYTES bytes.
  - cnt: ceil(log2(STATE_BYTES)) bits.
  - enc_r: 1 bit.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and has no dependence on in_valid.
- Accept: when in_valid & in_ready, load in_buf<=in_data, enc_r<=in_encrypt, cnt<=0, and go to RUN.
- RUN:
  - sbox_byte_in = in_buf[7:0].
  - Each cycle: res byte cnt <= sbox_byte_out, in_buf shifts right 8, cnt++.
  - When cnt==STATE_BYTES-1, capture the last byte and go to DONE. cnt does not wrap past STATE_BYTES-1.
- DONE:
  - out_valid=1; out_data=res, held stable until out_ready.
  - On out_ready with in_valid: accept the new transaction the same cycle and go straight to RUN.
  - On out_ready without in_valid: go to IDLE.
- sbox_encrypt = enc_r in all states.
- sbox_byte_in = 8'h00 in IDLE and DONE.
- out_data = res in every state. Its contents are meaningful only while out_valid=1.
- in_data and in_encrypt changes are ignored outside an accepting cycle. in_encrypt is never re-sampled mid-transaction.
- The block contains no S-box logic and never modifies sbox_byte_out.

## Timing
- Reset values: state=IDLE, out_valid=0, in_ready=1, sbox_byte_in=8'h00, sbox_encrypt=1 (enc_r resets to 1), out_data=0, cnt=0.
- Reset mid-operation: any in-flight transaction is discarded immediately and asynchronously. After release, the block is in IDLE and no out_valid pulse occurs.
- Latency: for acceptance at edge k, out_valid rises after edge k+STATE_BYTES (16 RUN cycles for STATE_BYTES=16).
- Throughput with back-to-back traffic and out_ready held at 1: one transaction per STATE_BYTES+1 cycles.
- Backpressure: out_valid stays high and out_data stays unchanged for any number of cycles with out_ready=0. in_ready=0 during that time.
- in_ready=0 throughout RUN. in_valid asserted during RUN is held off, not lost.
- Simultaneous out_ready & in_valid in DONE: the output transfer and the input acceptance both complete on the same edge, and out_valid falls on that edge.

## Test plan
- Forward, STATE_BYTES=16, bench S-box attached:
  - Stimulus: in_data=0x0f0e0d0c0b0a09080706050403020100, in_encrypt=1, out_ready=1.
  - Required: out_data=0x76abd7fe2b670130c56f6bf27b777c63; out_valid exactly 16 cycles after acceptance; sbox_byte_in sequence 00,01,...,0f.
- Inverse:
  - Stimulus: in_data with all bytes 0x63, in_encrypt=0.
  - Required: out_data=0; sbox_encrypt=0 for the whole transaction.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid, with in_valid held high.
  - Required: out_data stable, in_ready=0, no second acceptance until out_ready=1.
  - On that edge, the second transaction is accepted and RUN begins on the next cycle.
- Back-to-back:
  - Stimulus: 3 transactions with in_valid and out_ready held high, data 0x00.., 0x01.., 0x53.. (all bytes equal).
  - Required: outputs all-0x63, all-0x7c, all-0xed, spaced 17 cycles apart.
- Reset mid-RUN:
  - Stimulus: rst_n low at cycle 5 of RUN.
  - Required: out_valid=0 and in_ready=1 immediately. After release, a fresh transaction 0x0101.. returns all-0x7c with normal latency.
- STATE_BYTES=4:
  - Stimulus: in_data=0x0f0e0d0c, encrypt.
  - Required: out_data=0x76abd7fe after 4 RUN cycles.
